oflow_mem_buffer_fsm_write: RTL
===============================

# oflow_mem_buffer_fsm_write

Buffer-side write sequencer that accepts results from the core write FSM. The core presents a group of up to 4 bboxes with a `ready_from_core` pulse; this block latches the group and writes it into the buffer memory as two rows of two bboxes each. It then returns `done_write_buffer`, which lets the core advance its PE selection, and tracks the frame bbox count up to `frame_done`.

## Interface
- `DATA_W`, 64, bits per bbox record
- `ADDR_W`, 8, buffer memory row address width
- `NUM_BBOX_W`, 10, width of bbox count
- clk  in  1  clock
- reset_N  in  1  reset, asynchronous, active-low
- start_frame  in  1  pulse: clear counters/address, latch num_of_bbox_in_frame
- num_of_bbox_in_frame  in  NUM_BBOX_W  bboxes expected this frame
- ready_from_core  in  1  pulse: group valid on data_in this cycle
- remainder  in  2  0 = 4 valid bboxes, 1..3 = that many valid (bbox0 first)
- data_in  in  4*DATA_W  bbox0 in [DATA_W-1:0], bbox3 MSB
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory row address
- mem_wr_data  out  2*DATA_W  low half = even bbox
- mem_wr_mask  out  2  bit0 low half, bit1 high half
- done_write_buffer  out  1  one-cycle pulse, group fully written
- busy  out  1  high in any state except idle_st
- frame_done  out  1  level; set when written count reaches latched num, cleared by start_frame
- overrun_err  out  1  sticky until start_frame or reset

## Operation
- States: idle_st, wr_low_st, wr_high_st, done_st.
- idle_st: if ready_from_core and not frame_done:
  - latch data_in into group_reg;
  - latch valid_cnt = (remainder==0) ? 4 : remainder;
  - go to wr_low_st.
- wr_low_st:
  - mem_wr_en=1, data = bbox1:bbox0.
  - mask = 2'b01 if valid_cnt==1, else 2'b11.
  - Go to wr_high_st if valid_cnt>2, else to done_st.
  - Address increments after the write.
- wr_high_st:
  - mem_wr_en=1, data = bbox3:bbox2.
  - mask = 2'b11 if valid_cnt==4, else 2'b01.
  - Address increments; go to done_st.
- done_st:
  - done_write_buffer=1;
  - written_cnt += valid_cnt;
  - go to idle_st.
- frame_done sets the cycle after written_cnt (updated value) >= latched num.
- If num==0, frame_done sets the cycle after start_frame.
- Arithmetic: written_cnt is NUM_BBOX_W+1 bits with no overflow. mem_addr wraps modulo 2^ADDR_W silently.
- ready_from_core outside idle_st, or while frame_done=1: ignored, overrun_err set.
- start_frame in any state: next state idle_st; address, written_cnt and frame_done cleared; num latched.
- start_frame with simultaneous ready_from_core: start_frame wins, the ready is dropped, no error.
- Reset mid-group: all state discarded, no partial-write completion.

## Timing
- Reset values: mem_wr_en=0, mem_addr=0, mem_wr_data=0, mem_wr_mask=0, done_write_buffer=0, busy=0, frame_done=0, overrun_err=0.
- All outputs are registered/state-decoded and glitch-free.
- ready_from_core sampled at edge T:
  - low write visible T+1;
  - high write (if any) T+2;
  - done_write_buffer at T+3 (4 or 3 valid) or T+2 (1 or 2 valid).
- Maximum occupancy is 3 cycles. The core's 4-cycle ready spacing therefore never overruns.
- data_in is required stable only in the cycle ready_from_core is high.

## Structure
- Shared package oflow_mem_buffer_pkg holds:
  - state typedef;
  - constants BBOX_PER_GROUP=4 and BBOX_PER_ROW=2;
  - the remainder→valid_cnt function.
- Sub-module oflow_mem_buffer_wr_addr_gen: row address counter and written_cnt/frame_done logic, with inc, add_cnt and clear inputs. The FSM, group register and mask decode stay in the top module.

## Test plan
- start_frame num=8; two ready pulses (remainder=0) 4 cycles apart → 4 writes at addr 0..3, all mask 11. done_write_buffer pulses at T+3 of each group; frame_done=1 after the second.
- num=23: five full groups, then remainder=3 → last group writes addr 10 with mask 11 and addr 11 with mask 01. done at T+3, frame_done set.
- Final groups with remainder=1 and with remainder=2 (separate frames) → single write, masks 01 and 11 respectively, done at T+2.
- ready_from_core at T+1 of a group, and a ready after frame_done → overrun_err=1, no extra writes, address unchanged.
- start_frame during wr_high_st → no high write, state idle, mem_addr=0. A following group writes addr 0.
- Async reset asserted mid-group and num=0 start_frame → all outputs at reset values. frame_done=1 one cycle after start_frame.

Source files
------------

// File: rtl/oflow_mem_buffer_pkg.sv
// Shared types and constants for the buffer-side write sequencer.
package oflow_mem_buffer_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE_ST    = 2'd0;
  localparam logic [1:0] WR_LOW_ST  = 2'd1;
  localparam logic [1:0] WR_HIGH_ST = 2'd2;
  localparam logic [1:0] DONE_ST    = 2'd3;

  localparam int BBOX_PER_GROUP = 4;
  localparam int BBOX_PER_ROW   = 2;

  // remainder 0 encodes a full group of four
  function automatic logic [2:0] valid_cnt_f(input logic [1:0] remainder);
    return (remainder == 2'd0) ? 3'd4 : {1'b0, remainder};
  endfunction

endpackage

// File: rtl/oflow_mem_buffer_fsm_write_if.sv
// Buffer memory row-write bus; master drives, memory side is slave.
interface oflow_mem_buffer_fsm_write_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);
  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [2*DATA_W-1:0] mem_wr_data;
  logic [1:0]          mem_wr_mask;

  modport master (output mem_wr_en, output mem_addr, output mem_wr_data, output mem_wr_mask);
  modport slave  (input  mem_wr_en, input  mem_addr, input  mem_wr_data, input  mem_wr_mask);
endinterface

// File: rtl/oflow_mem_buffer_wr_addr_gen.sv
// Row address counter plus frame bbox accounting (written count vs latched target).
module oflow_mem_buffer_wr_addr_gen #(
  parameter int ADDR_W     = 8,
  parameter int NUM_BBOX_W = 10
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  i_clear,
  input  logic [NUM_BBOX_W-1:0] i_num,
  input  logic                  i_inc,
  input  logic                  i_add_cnt,
  input  logic [2:0]            i_add_val,
  output logic [ADDR_W-1:0]     o_addr,
  output logic                  o_frame_done
);

  logic [ADDR_W-1:0]     r_addr;
  logic [NUM_BBOX_W:0]   r_cnt;
  logic [NUM_BBOX_W-1:0] r_num;
  logic                  r_frame_done;
  logic [NUM_BBOX_W:0]   w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + {{(NUM_BBOX_W-2){1'b0}}, i_add_val};

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_addr       <= '0;
      r_cnt        <= '0;
      r_num        <= '0;
      r_frame_done <= 1'b0;
    end else if (i_clear) begin
      r_addr       <= '0;
      r_cnt        <= '0;
      r_num        <= i_num;
      // an empty frame is complete as soon as it starts
      r_frame_done <= (i_num == '0);
    end else begin
      if (i_inc)
        r_addr <= r_addr + ADDR_W'(1);
      if (i_add_cnt) begin
        r_cnt <= w_cnt_nxt;
        if (w_cnt_nxt >= {1'b0, r_num})
          r_frame_done <= 1'b1;
      end
    end
  end

  assign o_addr       = r_addr;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/oflow_mem_buffer_fsm_write.sv
// Latches a group of up to four bboxes from the core and writes it as two rows.
// state      | meaning
// IDLE_ST    | waiting for ready_from_core
// WR_LOW_ST  | writing bbox1:bbox0
// WR_HIGH_ST | writing bbox3:bbox2
// DONE_ST    | done_write_buffer pulse, bbox count updated
module oflow_mem_buffer_fsm_write
  import oflow_mem_buffer_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 8,
  parameter int NUM_BBOX_W = 10
) (
  input  logic                               clk,
  input  logic                               reset_N,
  input  logic                               i_start_frame,
  input  logic [NUM_BBOX_W-1:0]              i_num_of_bbox_in_frame,
  input  logic                               i_ready_from_core,
  input  logic [1:0]                         i_remainder,
  input  logic [BBOX_PER_GROUP*DATA_W-1:0]   i_data_in,
  output logic                               o_done_write_buffer,
  output logic                               o_busy,
  output logic                               o_frame_done,
  output logic                               o_overrun_err,
  oflow_mem_buffer_fsm_write_if.master       mem_if
);

  localparam int ROW_W = BBOX_PER_ROW * DATA_W;

  state_t            r_state;
  logic [ROW_W-1:0]  r_group_hi;
  logic [2:0]        r_valid_cnt;
  logic              r_mem_wr_en;
  logic [ROW_W-1:0]  r_mem_wr_data;
  logic [1:0]        r_mem_wr_mask;
  logic              r_done;
  logic              r_busy;
  logic              r_overrun;

  logic              w_frame_done;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_valid_in;
  logic              w_accept;

  assign w_valid_in = valid_cnt_f(i_remainder);
  assign w_accept   = i_ready_from_core && (r_state == IDLE_ST) && !w_frame_done;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state       <= IDLE_ST;
      r_group_hi    <= '0;
      r_valid_cnt   <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_data <= '0;
      r_mem_wr_mask <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (i_start_frame) begin
      // a simultaneous ready is dropped without flagging an error
      r_state       <= IDLE_ST;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_mask <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_mask <= '0;
      r_done        <= 1'b0;
      if (i_ready_from_core && !w_accept)
        r_overrun <= 1'b1;
      case (r_state)
        IDLE_ST: begin
          if (w_accept) begin
            r_group_hi    <= i_data_in[2*ROW_W-1:ROW_W];
            r_valid_cnt   <= w_valid_in;
            r_mem_wr_en   <= 1'b1;
            r_mem_wr_data <= i_data_in[ROW_W-1:0];
            r_mem_wr_mask <= (w_valid_in == 3'd1) ? 2'b01 : 2'b11;
            r_busy        <= 1'b1;
            r_state       <= WR_LOW_ST;
          end
        end
        WR_LOW_ST: begin
          if (r_valid_cnt > 3'd2) begin
            r_mem_wr_en   <= 1'b1;
            r_mem_wr_data <= r_group_hi;
            r_mem_wr_mask <= (r_valid_cnt == 3'd4) ? 2'b11 : 2'b01;
            r_state       <= WR_HIGH_ST;
          end else begin
            r_done  <= 1'b1;
            r_state <= DONE_ST;
          end
        end
        WR_HIGH_ST: begin
          r_done  <= 1'b1;
          r_state <= DONE_ST;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE_ST;
        end
      endcase
    end
  end

  // write strobe is high exactly in the two write states, so it doubles as the address step
  oflow_mem_buffer_wr_addr_gen #(
    .ADDR_W     (ADDR_W),
    .NUM_BBOX_W (NUM_BBOX_W)
  ) u_wr_addr_gen (
    .clk          (clk),
    .reset_N      (reset_N),
    .i_clear      (i_start_frame),
    .i_num        (i_num_of_bbox_in_frame),
    .i_inc        (r_mem_wr_en),
    .i_add_cnt    (r_done),
    .i_add_val    (r_valid_cnt),
    .o_addr       (w_addr),
    .o_frame_done (w_frame_done)
  );

  assign mem_if.mem_wr_en   = r_mem_wr_en;
  assign mem_if.mem_addr    = w_addr;
  assign mem_if.mem_wr_data = r_mem_wr_data;
  assign mem_if.mem_wr_mask = r_mem_wr_mask;

  assign o_done_write_buffer = r_done;
  assign o_busy              = r_busy;
  assign o_frame_done        = w_frame_done;
  assign o_overrun_err       = r_overrun;

endmodule
